counter_param: RTL and testbench
================================

// Module: counter_param
// PURPOSE
//   Parametrised multi-mode counter: WIDTH-bit up/down/step-down/load counter.
//   Carries ripple-carry (RCO) and load-strobe (LOAD) outputs for cascading and scoreboard checks.
//   Adds two things over the fixed 4-bit counter: a configurable step-down size and an optional saturating mode.
//   Sits under the counters testbench as the DUT, with the driver/checker/scoreboard around it.
// PARAMETERS
//   WIDTH     8   counter, D and Q width in bits (>=2)
//   STEP_DN   3   decrement applied in MODO=2'b10 (1 .. 2^WIDTH-1; 0 illegal)
//   SATURATE  0   0: wrap modulo 2^WIDTH; 1: clamp at 0 / 2^WIDTH-1
// PORTS
//   clk     in   1      single clock; all state changes on its rising edge
//   RESET   in   1      reset, asynchronous, active-low
//   ENABLE  in   1      1: execute MODO this cycle; 0: hold
//   MODO    in   2      00 up +1, 01 down -1, 10 down -STEP_DN, 11 load D
//   D       in   WIDTH  load value used when MODO=11
//   Q       out  WIDTH  counter value (registered)
//   RCO     out  1      one-cycle pulse: boundary crossed or clamped on this update (registered)
//   LOAD    out  1      one-cycle pulse: D loaded on this update (registered)
// BEHAVIOUR
//   Reset
//   - RESET=0 forces Q=0, RCO=0, LOAD=0 immediately (no clock needed), whatever the other inputs are.
//   - Counting resumes on the first rising clk edge that sees RESET=1.
//   Timing
//   - Inputs are sampled on the rising clk edge.
//   - Q, RCO and LOAD all update on that same edge; latency is 1 cycle from input to output.
//   - RCO and LOAD are never combinational.
//   ENABLE=0
//   - Q holds; RCO=0, LOAD=0. This applies for every MODO value, including 11 (no load when disabled).
//   ENABLE=1, MODO=00 (up)
//   - Q <= Q+1.
//   - If Q==2^WIDTH-1: wrap mode gives Q<=0, RCO=1; saturate mode holds Q, RCO=1.
//   ENABLE=1, MODO=01 (down by 1)
//   - Q <= Q-1.
//   - If Q==0: wrap mode gives Q<=2^WIDTH-1, RCO=1; saturate mode holds Q=0, RCO=1.
//   ENABLE=1, MODO=10 (down by STEP_DN)
//   - Q <= (Q-STEP_DN) mod 2^WIDTH.
//   - If Q<STEP_DN, RCO=1; in saturate mode Q<=0 instead of wrapping.
//   - Q==STEP_DN gives Q<=0 with RCO=0 (reaching exactly 0 is not a crossing).
//   ENABLE=1, MODO=11 (load)
//   - Q <= D, LOAD=1, RCO=0.
//   Outputs
//   - RCO and LOAD are never both 1.
//   - Each one is low on any cycle whose update did not cause it.
//   - A back-to-back condition gives back-to-back pulses (e.g. RCO stays 1 while a clamp repeats).
//   Arithmetic
//   - Internal add/sub is WIDTH+1 bits; the MSB is the crossing flag, and Q takes the low WIDTH bits.
//   - Changing MODO mid-count takes effect on the very next edge; there is no pipeline to flush.
// TESTING (WIDTH=8, STEP_DN=3 unless stated)
//   T1 async reset: count to 0x20, drop RESET between edges -> Q=0x00, RCO=0, LOAD=0 at once; 0x01 one edge after release with MODO=00.
//   T2 load + up wrap: D=0xFD, MODO=11 -> Q=0xFD, LOAD=1 for 1 cycle; then MODO=00 -> 0xFE, 0xFF, 0x00 (RCO=1 only on 0x00).
//   T3 step-down: load 0x04, MODO=10 -> 0x01 (RCO=0), then 0xFE (RCO=1); load 0x03, MODO=10 -> 0x00 with RCO=0.
//   T4 hold: Q=0x55, ENABLE=0 with MODO cycling 00..11 for 8 cycles -> Q stays 0x55, RCO=LOAD=0 throughout.
//   T5 SATURATE=1: load 0xFE, MODO=00 -> 0xFF, then 0xFF with RCO=1 each cycle; load 0x02, MODO=10 -> 0x00 with RCO=1; MODO=01 -> 0x00 with RCO=1.
//   T6 random: 100 cycles of random MODO/D/ENABLE plus sparse RESET pulses -> Q/RCO/LOAD match the scoreboard every cycle.

Source files
------------

// File: rtl/counter_param_if.sv
// -----------------------------------------------------------------------------
// counter_param_if
//   Bus between a counter_param instance and whatever drives it.
//
//   Signals
//     ENABLE  1      1: execute MODO this cycle; 0: hold
//     MODO    2      00 up +1, 01 down -1, 10 down -STEP_DN, 11 load D
//     D       WIDTH  load value used when MODO=11
//     Q       WIDTH  registered counter value
//     RCO     1      registered pulse: boundary crossed or clamped on this update
//     LOAD    1      registered pulse: D loaded on this update
//
//   Modports
//     master  drives ENABLE/MODO/D, observes Q/RCO/LOAD (driver side)
//     slave   the counter itself
// -----------------------------------------------------------------------------
interface counter_param_if #(
    parameter int WIDTH = 8
);
    logic             ENABLE;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             LOAD;

    modport master (
        output ENABLE, MODO, D,
        input  Q, RCO, LOAD
    );

    modport slave (
        input  ENABLE, MODO, D,
        output Q, RCO, LOAD
    );
endinterface : counter_param_if

// File: rtl/counter_param.sv
// -----------------------------------------------------------------------------
// counter_param
//   WIDTH-bit multi-mode counter: up by 1, down by 1, down by STEP_DN, or load.
//   RCO flags a boundary crossing (or a clamp in saturating mode) and LOAD
//   flags a load; both are registered one-cycle pulses updated with Q.
//
//   Parameters
//     WIDTH     counter width in bits (>= 2)
//     STEP_DN   decrement used for MODO=10 (1 .. 2^WIDTH-1)
//     SATURATE  0: wrap modulo 2^WIDTH; 1: clamp at 0 / 2^WIDTH-1
//
//   Ports
//     clk    rising-edge clock
//     RESET  asynchronous active-low reset; clears Q, RCO and LOAD
//     bus    counter_param_if.slave (ENABLE, MODO, D in; Q, RCO, LOAD out)
// -----------------------------------------------------------------------------
module counter_param #(
    parameter int          WIDTH    = 8,
    parameter int unsigned STEP_DN  = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            RESET,
    counter_param_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DN   = 2'b01,
        MODE_STEP = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Operands are one bit wider than Q so that the extra MSB of each
    // result is the carry/borrow, i.e. the crossing flag.
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP_DN);

    mode_e            mode;
    logic [WIDTH-1:0] q_r;
    logic             rco_r;
    logic             load_r;
    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             load_next;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_one;
    logic [WIDTH:0]   dn_step;

    assign mode    = mode_e'(bus.MODO);
    assign q_ext   = {1'b0, q_r};
    assign up_sum  = q_ext + ONE_EXT;
    assign dn_one  = q_ext - ONE_EXT;
    // Borrow is set only when Q < STEP_DN; landing exactly on 0 is not a crossing.
    assign dn_step = q_ext - STEP_EXT;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        q_next    = q_r;
        rco_next  = 1'b0;
        load_next = 1'b0;
        if (bus.ENABLE) begin
            unique case (mode)
                MODE_UP: begin
                    // Saturating at the top means "hold", which is Q itself.
                    q_next   = (SATURATE && up_sum[WIDTH]) ? q_r : up_sum[WIDTH-1:0];
                    rco_next = up_sum[WIDTH];
                end
                MODE_DN: begin
                    q_next   = (SATURATE && dn_one[WIDTH]) ? '0 : dn_one[WIDTH-1:0];
                    rco_next = dn_one[WIDTH];
                end
                MODE_STEP: begin
                    q_next   = (SATURATE && dn_step[WIDTH]) ? '0 : dn_step[WIDTH-1:0];
                    rco_next = dn_step[WIDTH];
                end
                MODE_LOAD: begin
                    q_next    = bus.D;
                    load_next = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            q_r    <= '0;
            rco_r  <= 1'b0;
            load_r <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            q_r    <= q_next;
            rco_r  <= rco_next;
            load_r <= load_next;
        end
    end

    assign bus.Q    = q_r;
    assign bus.RCO  = rco_r;
    assign bus.LOAD = load_r;

endmodule : counter_param

// File: tb/tb_counter_param.sv
// -----------------------------------------------------------------------------
// tb_counter_param
//   Directed bench for counter_param with WIDTH=8, STEP_DN=3. One instance
//   wraps (SATURATE=0), one saturates (SATURATE=1). Inputs change 1 time unit
//   after a rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_counter_param;

    logic clk;
    logic rst_w;
    logic rst_s;
    int   checks;
    int   errors;

    counter_param_if #(.WIDTH(8)) bw ();
    counter_param_if #(.WIDTH(8)) bs ();

    counter_param #(.WIDTH(8), .STEP_DN(3), .SATURATE(1'b0)) u_wrap (
        .clk   (clk),
        .RESET (rst_w),
        .bus   (bw.slave)
    );

    counter_param #(.WIDTH(8), .STEP_DN(3), .SATURATE(1'b1)) u_sat (
        .clk   (clk),
        .RESET (rst_s),
        .bus   (bs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [7:0] q, input logic rco, input logic load);
        check({tag, ".Q"},    32'(bw.Q),    32'(q));
        check({tag, ".RCO"},  32'(bw.RCO),  32'(rco));
        check({tag, ".LOAD"}, 32'(bw.LOAD), 32'(load));
    endtask

    task automatic chk_s(input string tag, input logic [7:0] q, input logic rco, input logic load);
        check({tag, ".Q"},    32'(bs.Q),    32'(q));
        check({tag, ".RCO"},  32'(bs.RCO),  32'(rco));
        check({tag, ".LOAD"}, 32'(bs.LOAD), 32'(load));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input logic en, input logic [1:0] modo, input logic [7:0] d);
        bw.ENABLE = en;
        bw.MODO   = modo;
        bw.D      = d;
    endtask

    task automatic drive_s(input logic en, input logic [1:0] modo, input logic [7:0] d);
        bs.ENABLE = en;
        bs.MODO   = modo;
        bs.D      = d;
    endtask

    // Reference behaviour written from integer arithmetic.
    task automatic model(input bit sat, input int q, input bit en, input int modo, input int d,
                         output int nq, output bit rco, output bit load);
        int t;
        nq   = q;
        rco  = 1'b0;
        load = 1'b0;
        if (en) begin
            case (modo)
                0: begin
                    t = q + 1;
                    if (t > 255) begin rco = 1'b1; t = sat ? 255 : 0; end
                    nq = t;
                end
                1: begin
                    t = q - 1;
                    if (t < 0) begin rco = 1'b1; t = sat ? 0 : 255; end
                    nq = t;
                end
                2: begin
                    t = q - 3;
                    if (t < 0) begin rco = 1'b1; t = sat ? 0 : t + 256; end
                    nq = t;
                end
                default: begin
                    nq   = d;
                    load = 1'b1;
                end
            endcase
        end
    endtask

    initial begin
        int  mq_w;
        int  mq_s;
        bit  mr_w, ml_w, mr_s, ml_s;
        bit  en;
        int  modo;
        int  d;

        checks = 0;
        errors = 0;
        rst_w  = 1'b0;
        rst_s  = 1'b0;
        drive_w(1'b1, 2'b00, 8'h00);
        drive_s(1'b0, 2'b00, 8'h00);

        // Reset state, held across edges while RESET is low
        tick();
        tick();
        chk_w("reset_w", 8'h00, 1'b0, 1'b0);
        chk_s("reset_s", 8'h00, 1'b0, 1'b0);
        rst_w = 1'b1;
        rst_s = 1'b1;

        // T1: count up to 0x20, load it (LOAD=1), then async reset mid-cycle
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk_w("t1_count", 8'(i), 1'b0, 1'b0);
        end
        drive_w(1'b1, 2'b11, 8'h20);
        tick();
        chk_w("t1_load20", 8'h20, 1'b0, 1'b1);
        #3;
        rst_w = 1'b0;
        #1;
        chk_w("t1_async_rst", 8'h00, 1'b0, 1'b0);
        drive_w(1'b1, 2'b00, 8'h00);
        tick();
        chk_w("t1_rst_held", 8'h00, 1'b0, 1'b0);
        rst_w = 1'b1;
        tick();
        chk_w("t1_release", 8'h01, 1'b0, 1'b0);

        // T2: load 0xFD then count up through the wrap
        drive_w(1'b1, 2'b11, 8'hFD);
        tick();
        chk_w("t2_load", 8'hFD, 1'b0, 1'b1);
        drive_w(1'b1, 2'b00, 8'h00);
        tick();
        chk_w("t2_fe", 8'hFE, 1'b0, 1'b0);
        tick();
        chk_w("t2_ff", 8'hFF, 1'b0, 1'b0);
        tick();
        chk_w("t2_wrap", 8'h00, 1'b1, 1'b0);
        tick();
        chk_w("t2_after", 8'h01, 1'b0, 1'b0);

        // T3: step-down by 3, crossing and exact-zero cases, then -1 wrap
        drive_w(1'b1, 2'b11, 8'h04);
        tick();
        chk_w("t3_load4", 8'h04, 1'b0, 1'b1);
        drive_w(1'b1, 2'b10, 8'h00);
        tick();
        chk_w("t3_step1", 8'h01, 1'b0, 1'b0);
        tick();
        chk_w("t3_step_cross", 8'hFE, 1'b1, 1'b0);
        drive_w(1'b1, 2'b11, 8'h03);
        tick();
        chk_w("t3_load3", 8'h03, 1'b0, 1'b1);
        drive_w(1'b1, 2'b10, 8'h00);
        tick();
        chk_w("t3_step_zero", 8'h00, 1'b0, 1'b0);
        drive_w(1'b1, 2'b01, 8'h00);
        tick();
        chk_w("t3_dn_wrap", 8'hFF, 1'b1, 1'b0);
        tick();
        chk_w("t3_dn", 8'hFE, 1'b0, 1'b0);

        // T4: hold with ENABLE=0 for every MODO, including load
        drive_w(1'b1, 2'b11, 8'h55);
        tick();
        chk_w("t4_load55", 8'h55, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive_w(1'b0, 2'(i), 8'hAA);
            tick();
            chk_w("t4_hold", 8'h55, 1'b0, 1'b0);
        end

        // T5: saturating instance
        drive_s(1'b1, 2'b11, 8'hFE);
        tick();
        chk_s("t5_loadfe", 8'hFE, 1'b0, 1'b1);
        drive_s(1'b1, 2'b00, 8'h00);
        tick();
        chk_s("t5_ff", 8'hFF, 1'b0, 1'b0);
        tick();
        chk_s("t5_clamp_hi1", 8'hFF, 1'b1, 1'b0);
        tick();
        chk_s("t5_clamp_hi2", 8'hFF, 1'b1, 1'b0);
        drive_s(1'b1, 2'b11, 8'h02);
        tick();
        chk_s("t5_load02", 8'h02, 1'b0, 1'b1);
        drive_s(1'b1, 2'b10, 8'h00);
        tick();
        chk_s("t5_step_clamp", 8'h00, 1'b1, 1'b0);
        drive_s(1'b1, 2'b01, 8'h00);
        tick();
        chk_s("t5_dn_clamp1", 8'h00, 1'b1, 1'b0);
        tick();
        chk_s("t5_dn_clamp2", 8'h00, 1'b1, 1'b0);
        drive_s(1'b1, 2'b00, 8'h00);
        tick();
        chk_s("t5_up", 8'h01, 1'b0, 1'b0);

        // T6: random stimulus on both instances with sparse reset pulses
        mq_w = int'(bw.Q);
        mq_s = 1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_w = 1'b0;
                rst_s = 1'b0;
                #1;
                mq_w = 0;
                mq_s = 0;
                chk_w("t6_rst_w", 8'h00, 1'b0, 1'b0);
                chk_s("t6_rst_s", 8'h00, 1'b0, 1'b0);
                tick();
                rst_w = 1'b1;
                rst_s = 1'b1;
            end else begin
                en   = ($urandom_range(0, 3) != 0);
                modo = int'($urandom_range(0, 3));
                d    = int'($urandom_range(0, 255));
                drive_w(en, 2'(modo), 8'(d));
                drive_s(en, 2'(modo), 8'(d));
                model(1'b0, mq_w, en, modo, d, mq_w, mr_w, ml_w);
                model(1'b1, mq_s, en, modo, d, mq_s, mr_s, ml_s);
                tick();
                chk_w("t6_w", 8'(mq_w), mr_w, ml_w);
                chk_s("t6_s", 8'(mq_s), mr_s, ml_s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_param
